// File: rtl/uart_rx_block.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// one-deep holding register with read handshake, framing/overrun pulses.
module uart_rx_block #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       read_rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_busy,
  output logic       framing_error,
  output logic       overrun_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // The edge that enters START already counts as the first half-bit cycle,
  // so the start-bit centre is reached when the counter reads H-2.
  localparam logic [CNT_W-1:0] START_SMP = CNT_W'(CLKS_PER_BIT/2 - 2);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state_q;
  logic             sync1_q;
  logic             rxs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_ready_q;
  logic             rx_busy_q;
  logic             fe_q;
  logic             oe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
      rx_busy_q  <= 1'b0;
      fe_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      sync1_q <= serial_in;
      rxs_q   <= sync1_q;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
      if (read_rx && rx_ready_q) begin
        rx_ready_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            state_q   <= START;
            cnt_q     <= '0;
            rx_busy_q <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == START_SMP) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            if (rxs_q) begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rxs_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rxs_q) begin
              // A read in this same cycle frees the register for the new byte.
              if (!rx_ready_q || read_rx) begin
                rx_data_q  <= shift_q;
                rx_ready_q <= 1'b1;
              end else begin
                oe_q <= 1'b1;
              end
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              fe_q    <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        WAIT_HIGH: begin
          if (rxs_q) begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_ready      = rx_ready_q;
  assign rx_busy       = rx_busy_q;
  assign framing_error = fe_q;
  assign overrun_error = oe_q;

endmodule

// File: tb/tb_uart_rx_block.sv
// Bench for uart_rx_block: directed frames plus random traffic, checked every
// cycle against a sample-schedule model of the receiver.
module tb_uart_rx_block;

  localparam int C = 8;
  localparam int H = C / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       read_rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_busy;
  logic       framing_error;
  logic       overrun_error;

  uart_rx_block #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .read_rx      (read_rx),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_busy      (rx_busy),
    .framing_error(framing_error),
    .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: 0 idle, 1 inside a frame (m_t edges since START entry), 2 waiting for high.
  int         m_mode;
  int         m_t;
  logic [7:0] m_bits;
  logic [7:0] m_data;
  logic       m_ready, m_busy, m_fe, m_oe;
  logic       m_d1, m_d2;

  int   edge_no = 0;
  int   ready_rise_edge = 0;
  int   fe_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic prev_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic model_step(input logic p, input logic rd, input logic rst);
    logic line;
    logic load;
    int   k;
    if (rst) begin
      m_mode = 0; m_t = 0; m_bits = '0; m_data = '0;
      m_ready = 1'b0; m_busy = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
      m_d1 = 1'b1; m_d2 = 1'b1;
      return;
    end
    line = m_d2;
    m_d2 = m_d1;
    m_d1 = p;
    m_fe = 1'b0;
    m_oe = 1'b0;
    load = 1'b0;
    case (m_mode)
      0: if (!line) begin m_mode = 1; m_t = 0; end
      1: begin
        m_t++;
        if (m_t == H - 1) begin
          if (line) m_mode = 0;
        end else if (m_t == H - 1 + 9 * C) begin
          if (line) begin
            if (!m_ready || rd) load = 1'b1;
            else m_oe = 1'b1;
            m_mode = 0;
          end else begin
            m_fe = 1'b1;
            m_mode = 2;
          end
        end else if (m_t > H - 1 && ((m_t - (H - 1)) % C) == 0) begin
          k = (m_t - (H - 1)) / C - 1;
          m_bits[k] = line;
        end
      end
      default: if (line) m_mode = 0;
    endcase
    if (rd && m_ready) m_ready = 1'b0;
    if (load) begin m_data = m_bits; m_ready = 1'b1; end
    m_busy = (m_mode != 0);
  endtask

  task automatic cycle(input logic p, input logic rd, input logic rst);
    serial_in = p;
    read_rx   = rd;
    reset     = rst;
    @(posedge clk);
    edge_no++;
    model_step(p, rd, rst);
    @(negedge clk);
    chk("rx_data", rx_data, m_data);
    chk("rx_ready", rx_ready, m_ready);
    chk("rx_busy", rx_busy, m_busy);
    chk("framing_error", framing_error, m_fe);
    chk("overrun_error", overrun_error, m_oe);
    if (rx_ready && !prev_ready) ready_rise_edge = edge_no;
    prev_ready = rx_ready;
    if (framing_error) fe_cnt++;
    if (overrun_error) oe_cnt++;
    if (rx_busy) busy_cnt++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_at,
                            input int rst_at, output int e0);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    e0 = edge_no + 1;
    for (int i = 0; i < 10 * C; i++) cycle(fr[i / C], i == rd_at, i == rst_at);
  endtask

  initial begin
    int         e0, e1;
    logic [7:0] d;
    logic       stp;
    logic [9:0] fr;
    int         gap;

    serial_in = 1'b1;
    read_rx   = 1'b0;
    reset     = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, 1'b1);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_ready", rx_ready, 1'b0);
    chk("reset_rx_busy", rx_busy, 1'b0);
    chk("reset_errors", {framing_error, overrun_error}, 2'b00);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);

    // Back-to-back good frames; the first is read during the second.
    fe_cnt = 0; oe_cnt = 0;
    send_frame(8'hF0, 1'b1, -1, -1, e0);
    chk("f0_ready_edge", ready_rise_edge - e0, 77);
    chk("f0_data", rx_data, 8'hF0);
    send_frame(8'hD3, 1'b1, 5, -1, e1);
    chk("d3_ready_edge", ready_rise_edge - e0, 157);
    chk("d3_data", rx_data, 8'hD3);
    chk("good_no_errors", fe_cnt + oe_cnt, 0);
    repeat (6) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("read_clears_ready", rx_ready, 1'b0);

    // False start: 2-cycle glitch.
    busy_cnt = 0; fe_cnt = 0; oe_cnt = 0;
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    repeat (20) cycle(1'b1, 1'b0, 1'b0);
    chk("glitch_busy_seen", busy_cnt > 0, 1);
    chk("glitch_data_kept", rx_data, 8'hD3);
    chk("glitch_no_ready", rx_ready, 1'b0);
    chk("glitch_no_errors", fe_cnt + oe_cnt, 0);

    // Framing error followed by a held-low break.
    fe_cnt = 0;
    send_frame(8'h55, 1'b0, -1, -1, e0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    chk("break_busy_held", rx_busy, 1'b1);
    repeat (20) cycle(1'b1, 1'b0, 1'b0);
    chk("framing_pulses", fe_cnt, 1);
    chk("framing_no_ready", rx_ready, 1'b0);
    chk("framing_busy_low", rx_busy, 1'b0);

    // Overrun: second byte arrives while first is unread.
    oe_cnt = 0;
    send_frame(8'hA5, 1'b1, -1, -1, e0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, -1, -1, e1);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    chk("overrun_pulses", oe_cnt, 1);
    chk("overrun_data_kept", rx_data, 8'hA5);
    chk("overrun_ready", rx_ready, 1'b1);

    // Read exactly on the stop-sample edge.
    oe_cnt = 0;
    send_frame(8'h3C, 1'b1, 77, -1, e0);
    chk("coincident_data", rx_data, 8'h3C);
    chk("coincident_ready", rx_ready, 1'b1);
    chk("coincident_no_overrun", oe_cnt, 0);
    cycle(1'b1, 1'b1, 1'b0);

    // Reset during data bit 4 of 0xFF, then a clean 0x81.
    send_frame(8'hFF, 1'b1, -1, 40, e0);
    chk("midreset_data", rx_data, 8'h00);
    chk("midreset_ready", rx_ready, 1'b0);
    chk("midreset_busy", rx_busy, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, -1, -1, e0);
    chk("after_reset_data", rx_data, 8'h81);
    chk("after_reset_ready_edge", ready_rise_edge - e0, 77);

    // Random traffic with random reads, gaps and bad stop bits.
    for (int f = 0; f < 30; f++) begin
      d   = 8'($urandom);
      stp = ($urandom_range(7) != 0);
      gap = $urandom_range(3);
      fr  = {stp, d, 1'b0};
      for (int i = 0; i < 10 * C; i++) cycle(fr[i / C], $urandom_range(15) == 0, 1'b0);
      for (int g = 0; g < gap; g++) cycle(1'b1, $urandom_range(15) == 0, 1'b0);
    end
    repeat (30) cycle(1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
